// File: rtl/pll_pwr_seq.sv
// pll_pwr_seq: PLL power-up, lock qualification and retry supervisor.
// Runs on the PLL reference clock; every output is registered.
module pll_pwr_seq #(
  parameter int PWD_CYCLES   = 3,
  parameter int RST_CYCLES   = 3,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RETRY_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PWD    = 3'd0,
    S_RST    = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam int T1 =
    (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int T2 =
    (T1 > LOCK_STABLE) ? T1 : LOCK_STABLE;
  localparam int TMAX =
    (T2 > LOCK_TIMEOUT) ? T2 : LOCK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW =
    (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [TW-1:0] PWD_LAST = TW'(PWD_CYCLES - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] TRY_LAST = RW'(RETRY_MAX);

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [RW-1:0]   retry_q;
  logic [RW-1:0]   retry_d;
  logic [7:0]      loss_d;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic            go;

  assign lock_s = sync_q[1];
  assign state  = state_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_cnt;
    go      = 1'b0;
    unique case (state_q)
      S_PWD: begin
        if (timer_q == PWD_LAST) begin
          state_d = S_RST;
          go      = 1'b1;
        end
      end
      S_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT;
          go      = 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          go      = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          go = 1'b1;
          if (retry_q == TRY_LAST) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = S_PWD;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          go      = 1'b1;
        end else if (timer_q == STB_LAST) begin
          state_d = S_RUN;
          go      = 1'b1;
        end
      end
      // Lock loss re-locks via RST only; the PLL stays powered.
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RST;
          retry_d = '0;
          go      = 1'b1;
          if (loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
        end
      end
      S_FAIL: begin
      end
      default: begin
        state_d = S_PWD;
        go      = 1'b1;
      end
    endcase
    if (restart) begin
      state_d = S_PWD;
      retry_d = '0;
      go      = 1'b1;
    end
    timer_d = go ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PWD;
      timer_q  <= '0;
      retry_q  <= '0;
      sync_q   <= '0;
      loss_cnt <= '0;
      pll_pwd  <= 1'b1;
      pll_rst  <= 1'b1;
      ready    <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      sync_q   <= {sync_q[0], lock};
      loss_cnt <= loss_d;
      pll_pwd  <= (state_d == S_PWD) || (state_d == S_FAIL);
      pll_rst  <= (state_d == S_PWD) || (state_d == S_FAIL)
               || (state_d == S_RST);
      ready    <= (state_d == S_RUN);
      fail     <= (state_d == S_FAIL);
    end
  end

endmodule
